// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings, processor status codes and SEQ controller types.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'd0;
    localparam logic [3:0] I_NOP    = 4'd1;
    localparam logic [3:0] I_RRMOVQ = 4'd2;
    localparam logic [3:0] I_IRMOVQ = 4'd3;
    localparam logic [3:0] I_RMMOVQ = 4'd4;
    localparam logic [3:0] I_MRMOVQ = 4'd5;
    localparam logic [3:0] I_OPQ    = 4'd6;
    localparam logic [3:0] I_JXX    = 4'd7;
    localparam logic [3:0] I_CALL   = 4'd8;
    localparam logic [3:0] I_RET    = 4'd9;
    localparam logic [3:0] I_PUSHQ  = 4'd10;
    localparam logic [3:0] I_POPQ   = 4'd11;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_MEMORY,
        ST_WRITEBACK,
        ST_PCUPD,
        ST_HALTED,
        ST_FAULT
    } seq_state_e;

    localparam int STG_FETCH = 0;
    localparam int STG_DEC   = 1;
    localparam int STG_EXE   = 2;
    localparam int STG_MEM   = 3;
    localparam int STG_WB    = 4;
    localparam int STG_PCUPD = 5;

    // Instructions that touch data memory and therefore wait for mem_done.
    function automatic logic is_mem_icode(input logic [3:0] icode);
        return (icode == I_RMMOVQ) || (icode == I_MRMOVQ) || (icode == I_CALL) ||
               (icode == I_RET) || (icode == I_PUSHQ) || (icode == I_POPQ);
    endfunction

endpackage

// File: rtl/seq_stage_ctrl_if.sv
// Bundle between the SEQ controller (master) and the fetch/execute/memory datapath (slave).
interface seq_stage_ctrl_if;
    logic        start;
    logic [3:0]  in_code;
    logic        cnd;
    logic [63:0] val_c;
    logic [63:0] val_p;
    logic [63:0] val_m;
    logic        flag_halt;
    logic        bad_mem;
    logic        in_error;
    logic        mem_done;
    logic        dmem_error;
    logic [63:0] p_ctr;
    logic [5:0]  stage_en;
    logic [2:0]  stat;
    logic        running;
    logic [31:0] retired;

    modport master (
        input  start, in_code, cnd, val_c, val_p, val_m,
               flag_halt, bad_mem, in_error, mem_done, dmem_error,
        output p_ctr, stage_en, stat, running, retired
    );

    modport slave (
        output start, in_code, cnd, val_c, val_p, val_m,
               flag_halt, bad_mem, in_error, mem_done, dmem_error,
        input  p_ctr, stage_en, stat, running, retired
    );
endinterface

// File: rtl/seq_next_pc.sv
// Combinational next-PC select for the PC-update stage.
module seq_next_pc
    import y86_pkg::*;
(
    input  logic [3:0]  icode,
    input  logic        cnd,
    input  logic [63:0] val_c,
    input  logic [63:0] val_p,
    input  logic [63:0] val_m,
    output logic [63:0] next_pc
);

    always_comb begin
        next_pc = val_p;
        case (icode)
            I_CALL:  next_pc = val_c;
            I_JXX:   next_pc = cnd ? val_c : val_p;
            I_RET:   next_pc = val_m;
            default: next_pc = val_p;
        endcase
    end

endmodule

// File: rtl/seq_stage_ctrl.sv
// SEQ sequencing controller: owns the PC, steps the six stages and tracks processor status.
module seq_stage_ctrl
    import y86_pkg::*;
#(
    parameter logic [63:0] RESET_PC    = 64'd0,
    parameter logic [63:0] MEM_LIMIT   = 64'd1023,
    parameter logic [3:0]  MEM_TIMEOUT = 4'd15
) (
    input  logic             clock,
    input  logic             reset_n,
    seq_stage_ctrl_if.master bus
);

    seq_state_e  state_q, state_d;
    logic [63:0] p_ctr_q, p_ctr_d;
    logic [5:0]  stage_en_q, stage_en_d;
    logic [2:0]  stat_q, stat_d;
    logic        running_q, running_d;
    logic [31:0] retired_q, retired_d;
    logic [3:0]  tmo_q, tmo_d;
    logic [3:0]  icode_q, icode_d;
    logic [63:0] val_c_q, val_c_d;
    logic [63:0] val_p_q, val_p_d;
    logic [63:0] val_m_q, val_m_d;
    logic        cnd_q, cnd_d;
    logic [63:0] next_pc;
    logic        fetch_fault;
    logic        mem_waiting;
    logic        mem_expired;

    seq_next_pc u_next_pc (
        .icode   (icode_q),
        .cnd     (cnd_q),
        .val_c   (val_c_q),
        .val_p   (val_p_q),
        .val_m   (val_m_q),
        .next_pc (next_pc)
    );

    assign fetch_fault = bus.in_error || bus.bad_mem || (p_ctr_q > MEM_LIMIT);
    assign mem_waiting = (state_q == ST_MEMORY) && is_mem_icode(icode_q) && !bus.mem_done;
    assign mem_expired = mem_waiting && ((tmo_q + 4'd1) == MEM_TIMEOUT);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            p_ctr_q    <= RESET_PC;
            stage_en_q <= '0;
            stat_q     <= STAT_AOK;
            running_q  <= 1'b0;
            retired_q  <= '0;
            tmo_q      <= '0;
            icode_q    <= I_NOP;
            val_c_q    <= '0;
            val_p_q    <= '0;
            val_m_q    <= '0;
            cnd_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            p_ctr_q    <= p_ctr_d;
            stage_en_q <= stage_en_d;
            stat_q     <= stat_d;
            running_q  <= running_d;
            retired_q  <= retired_d;
            tmo_q      <= tmo_d;
            icode_q    <= icode_d;
            val_c_q    <= val_c_d;
            val_p_q    <= val_p_d;
            val_m_q    <= val_m_d;
            cnd_q      <= cnd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (bus.start) state_d = ST_FETCH;
            ST_FETCH: begin
                if (fetch_fault)        state_d = ST_FAULT;
                else if (bus.flag_halt) state_d = ST_HALTED;
                else                    state_d = ST_DECODE;
            end
            ST_DECODE:    state_d = ST_EXECUTE;
            ST_EXECUTE:   state_d = ST_MEMORY;
            // A data fault wins even over a completing access.
            ST_MEMORY: begin
                if (bus.dmem_error || mem_expired)                 state_d = ST_FAULT;
                else if (!is_mem_icode(icode_q) || bus.mem_done)   state_d = ST_WRITEBACK;
            end
            ST_WRITEBACK: state_d = ST_PCUPD;
            ST_PCUPD:     state_d = ST_FETCH;
            default:      state_d = state_q;
        endcase
    end

    always_comb begin
        p_ctr_d    = p_ctr_q;
        stat_d     = stat_q;
        retired_d  = retired_q;
        tmo_d      = tmo_q;
        icode_d    = icode_q;
        val_c_d    = val_c_q;
        val_p_d    = val_p_q;
        val_m_d    = val_m_q;
        cnd_d      = cnd_q;
        stage_en_d = '0;
        case (state_d)
            ST_FETCH:     stage_en_d[STG_FETCH] = 1'b1;
            ST_DECODE:    stage_en_d[STG_DEC]   = 1'b1;
            ST_EXECUTE:   stage_en_d[STG_EXE]   = 1'b1;
            ST_MEMORY:    stage_en_d[STG_MEM]   = 1'b1;
            ST_WRITEBACK: stage_en_d[STG_WB]    = 1'b1;
            ST_PCUPD:     stage_en_d[STG_PCUPD] = 1'b1;
            default:      stage_en_d = '0;
        endcase
        running_d = |stage_en_d;

        case (state_q)
            ST_IDLE: begin
                if (state_d == ST_FETCH) begin
                    p_ctr_d = RESET_PC;
                    stat_d  = STAT_AOK;
                end
            end
            ST_FETCH: begin
                icode_d = bus.in_code;
                val_c_d = bus.val_c;
                val_p_d = bus.val_p;
                if (state_d == ST_FAULT) begin
                    stat_d = bus.in_error ? STAT_INS : STAT_ADR;
                end else if (state_d == ST_HALTED) begin
                    stat_d    = STAT_HLT;
                    p_ctr_d   = bus.val_p;
                    retired_d = retired_q + 32'd1;
                end
            end
            ST_EXECUTE: cnd_d = bus.cnd;
            ST_MEMORY: begin
                if (bus.mem_done) val_m_d = bus.val_m;
                tmo_d = (state_d == ST_MEMORY) ? tmo_q + 4'd1 : 4'd0;
                if (state_d == ST_FAULT) stat_d = STAT_ADR;
            end
            ST_PCUPD: begin
                p_ctr_d   = next_pc;
                retired_d = retired_q + 32'd1;
            end
            default: ;
        endcase
    end

    assign bus.p_ctr    = p_ctr_q;
    assign bus.stage_en = stage_en_q;
    assign bus.stat     = stat_q;
    assign bus.running  = running_q;
    assign bus.retired  = retired_q;

endmodule

// File: tb/tb_seq_stage_ctrl.sv
// Bench for seq_stage_ctrl: directed scenarios plus a random instruction stream against a PC/retire model.
module tb_seq_stage_ctrl;

    logic clock;
    logic reset_n;
    seq_stage_ctrl_if bus ();

    seq_stage_ctrl dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          chk_cnt;
    int          pass_cnt;
    logic [63:0] m_pc;
    logic [31:0] m_retired;
    logic [5:0]  obs_stage [64];
    int          obs_n;
    int          obs_mem;
    bit          obs_timeout;

    function automatic bit model_is_mem(input logic [3:0] ic);
        return (ic == 4'd4) || (ic == 4'd5) || ((ic >= 4'd8) && (ic <= 4'd11));
    endfunction

    function automatic logic [63:0] model_next_pc(input logic [3:0] ic, input logic [63:0] vc,
                                                  input logic [63:0] vp, input logic [63:0] vm,
                                                  input logic c);
        if (ic == 4'd8 || (ic == 4'd7 && c)) return vc;
        if (ic == 4'd9) return vm;
        return vp;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        bus.start      = 1'b0;
        bus.in_code    = 4'd1;
        bus.cnd        = 1'b0;
        bus.val_c      = '0;
        bus.val_p      = '0;
        bus.val_m      = '0;
        bus.flag_halt  = 1'b0;
        bus.bad_mem    = 1'b0;
        bus.in_error   = 1'b0;
        bus.mem_done   = 1'b0;
        bus.dmem_error = 1'b0;
    endtask

    // Reset, then start; returns with the controller in its first FETCH cycle.
    task automatic restart();
        clear_inputs();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n   = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        m_pc      = 64'd0;
        m_retired = 32'd0;
    endtask

    // Drives one instruction from its FETCH cycle until the next FETCH (or a stop) and records
    // the observed stage strobes; val_m is only valid while mem_done is high.
    task automatic exec_instr(input logic [3:0] ic, input logic [63:0] vc, input logic [63:0] vp,
                              input logic [63:0] vm, input logic c, input int wait_cycles);
        int  mem_seen;
        bit  done;
        clear_inputs();
        bus.in_code = ic;
        bus.val_c   = vc;
        bus.val_p   = vp;
        bus.cnd     = c;
        bus.val_m   = ~vm;
        obs_n       = 0;
        obs_timeout = 1'b0;
        mem_seen    = 0;
        done        = 1'b0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            if (obs_n < 64) obs_stage[obs_n] = bus.stage_en;
            obs_n++;
            if (bus.stage_en == 6'b001000) begin
                bus.mem_done = (mem_seen == wait_cycles);
                mem_seen++;
            end else begin
                bus.mem_done = 1'b0;
            end
            bus.val_m = bus.mem_done ? vm : ~vm;
            tick();
            if (bus.stage_en == 6'b000001 || bus.stage_en == 6'b000000) done = 1'b1;
        end
        bus.mem_done = 1'b0;
        obs_mem      = mem_seen;
        if (!done) obs_timeout = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset_n = 1'b0;
        tick();
        tick();
        chk_cnt++;
        if (bus.stage_en !== 6'd0) $display("[TB] FAIL reset_stage_en: got %0h expected 0", bus.stage_en);
        else pass_cnt++;
        chk_cnt++;
        if (bus.p_ctr !== 64'd0) $display("[TB] FAIL reset_p_ctr: got %0h expected 0", bus.p_ctr);
        else pass_cnt++;
        chk_cnt++;
        if (bus.stat !== 3'd1) $display("[TB] FAIL reset_stat: got %0d expected 1", bus.stat);
        else pass_cnt++;
        chk_cnt++;
        if (bus.running !== 1'b0 || bus.retired !== 32'd0)
            $display("[TB] FAIL reset_running_retired: got %b/%0d expected 0/0", bus.running, bus.retired);
        else pass_cnt++;
        reset_n = 1'b1;
        tick();
        tick();
        chk_cnt++;
        if (bus.stage_en !== 6'd0 || bus.running !== 1'b0)
            $display("[TB] FAIL idle_without_start: got %0h/%b expected 0/0", bus.stage_en, bus.running);
        else pass_cnt++;
    endtask

    task automatic test_irmovq();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        m_pc = 64'd0;
        m_retired = 32'd0;
        chk_cnt++;
        if (bus.stage_en !== 6'd1 || bus.running !== 1'b1 || bus.p_ctr !== 64'd0)
            $display("[TB] FAIL start_fetch: got %0h/%b/%0h expected 1/1/0", bus.stage_en, bus.running, bus.p_ctr);
        else pass_cnt++;
        exec_instr(4'd3, 64'h55, 64'd10, 64'd0, 1'b0, 0);
        m_pc = 64'd10;
        m_retired++;
        for (int k = 0; k < 6; k++) begin
            chk_cnt++;
            if (obs_stage[k] !== (6'd1 << k))
                $display("[TB] FAIL irmovq_stage%0d: got %0h expected %0h", k, obs_stage[k], 6'd1 << k);
            else pass_cnt++;
        end
        chk_cnt++;
        if (obs_n !== 6 || bus.p_ctr !== m_pc || bus.retired !== m_retired)
            $display("[TB] FAIL irmovq_result: got n=%0d pc=%0h ret=%0d expected n=6 pc=%0h ret=%0d",
                     obs_n, bus.p_ctr, bus.retired, m_pc, m_retired);
        else pass_cnt++;
    endtask

    task automatic test_jxx();
        exec_instr(4'd7, 64'd39, 64'd39, 64'd0, 1'b0, 0);
        chk_cnt++;
        if (bus.p_ctr !== 64'd39) $display("[TB] FAIL jxx_not_taken: got %0h expected 27", bus.p_ctr);
        else pass_cnt++;
        exec_instr(4'd7, 64'd122, 64'd39, 64'd0, 1'b1, 0);
        m_pc = 64'd122;
        m_retired += 2;
        chk_cnt++;
        if (bus.p_ctr !== 64'd122 || bus.retired !== m_retired)
            $display("[TB] FAIL jxx_taken: got %0h/%0d expected 7a/%0d", bus.p_ctr, bus.retired, m_retired);
        else pass_cnt++;
    endtask

    task automatic test_ret_wait();
        exec_instr(4'd9, 64'd5, 64'd130, 64'h46, 1'b0, 3);
        m_pc = 64'h46;
        m_retired++;
        chk_cnt++;
        if (obs_mem !== 4 || obs_n !== 9)
            $display("[TB] FAIL ret_mem_cycles: got mem=%0d n=%0d expected mem=4 n=9", obs_mem, obs_n);
        else pass_cnt++;
        chk_cnt++;
        if (bus.p_ctr !== m_pc) $display("[TB] FAIL ret_target: got %0h expected %0h", bus.p_ctr, m_pc);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [3:0]  ic;
        logic [63:0] vc, vp, vm;
        logic        c;
        int          w;
        int          exp_mem;
        for (int n = 0; n < 24; n++) begin
            ic = 4'($urandom_range(11, 1));
            vc = 64'($urandom_range(1023, 0));
            vp = 64'($urandom_range(1023, 0));
            vm = 64'($urandom_range(1023, 0));
            c  = 1'($urandom_range(1, 0));
            w  = $urandom_range(5, 0);
            exec_instr(ic, vc, vp, vm, c, w);
            exp_mem   = model_is_mem(ic) ? w + 1 : 1;
            m_pc      = model_next_pc(ic, vc, vp, vm, c);
            m_retired++;
            chk_cnt++;
            if (obs_timeout || obs_n !== 5 + exp_mem)
                $display("[TB] FAIL rand%0d_cycles: got %0d expected %0d (icode %0d)", n, obs_n, 5 + exp_mem, ic);
            else pass_cnt++;
            chk_cnt++;
            if (obs_mem !== exp_mem)
                $display("[TB] FAIL rand%0d_mem: got %0d expected %0d (icode %0d)", n, obs_mem, exp_mem, ic);
            else pass_cnt++;
            chk_cnt++;
            if (bus.p_ctr !== m_pc)
                $display("[TB] FAIL rand%0d_pc: got %0h expected %0h (icode %0d)", n, bus.p_ctr, m_pc, ic);
            else pass_cnt++;
            chk_cnt++;
            if (bus.retired !== m_retired || bus.stat !== 3'd1)
                $display("[TB] FAIL rand%0d_retired: got %0d/%0d expected %0d/1", n, bus.retired, bus.stat, m_retired);
            else pass_cnt++;
        end
    endtask

    task automatic test_fetch_limit();
        restart();
        exec_instr(4'd1, 64'd0, 64'd1023, 64'd0, 1'b0, 0);
        exec_instr(4'd1, 64'd0, 64'd1024, 64'd0, 1'b0, 0);
        chk_cnt++;
        if (obs_n !== 6 || bus.p_ctr !== 64'd1024 || bus.stage_en !== 6'd1)
            $display("[TB] FAIL limit_edge_legal: got n=%0d pc=%0h en=%0h expected n=6 pc=400 en=1",
                     obs_n, bus.p_ctr, bus.stage_en);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (bus.stat !== 3'd3 || bus.stage_en !== 6'd0 || bus.p_ctr !== 64'd1024)
            $display("[TB] FAIL limit_over_adr: got stat=%0d en=%0h pc=%0h expected 3/0/400",
                     bus.stat, bus.stage_en, bus.p_ctr);
        else pass_cnt++;
    endtask

    task automatic test_halt();
        restart();
        exec_instr(4'd1, 64'd0, 64'd70, 64'd0, 1'b0, 0);
        clear_inputs();
        bus.in_code   = 4'd0;
        bus.flag_halt = 1'b1;
        bus.val_p     = 64'd71;
        tick();
        chk_cnt++;
        if (bus.stat !== 3'd2 || bus.p_ctr !== 64'd71 || bus.running !== 1'b0 || bus.retired !== 32'd2)
            $display("[TB] FAIL halt_entry: got stat=%0d pc=%0h run=%b ret=%0d expected 2/47/0/2",
                     bus.stat, bus.p_ctr, bus.running, bus.retired);
        else pass_cnt++;
        bus.flag_halt = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.start = (k % 2 == 0);
            tick();
        end
        bus.start = 1'b0;
        chk_cnt++;
        if (bus.stat !== 3'd2 || bus.stage_en !== 6'd0 || bus.p_ctr !== 64'd71 || bus.retired !== 32'd2)
            $display("[TB] FAIL halt_ignores_start: got stat=%0d en=%0h pc=%0h ret=%0d expected 2/0/47/2",
                     bus.stat, bus.stage_en, bus.p_ctr, bus.retired);
        else pass_cnt++;
    endtask

    task automatic test_fetch_errors();
        restart();
        bus.in_error = 1'b1;
        bus.bad_mem  = 1'b1;
        tick();
        chk_cnt++;
        if (bus.stat !== 3'd4 || bus.stage_en !== 6'd0 || bus.running !== 1'b0 || bus.retired !== 32'd0)
            $display("[TB] FAIL ins_priority: got stat=%0d en=%0h run=%b ret=%0d expected 4/0/0/0",
                     bus.stat, bus.stage_en, bus.running, bus.retired);
        else pass_cnt++;
        restart();
        bus.bad_mem = 1'b1;
        tick();
        chk_cnt++;
        if (bus.stat !== 3'd3 || bus.stage_en !== 6'd0)
            $display("[TB] FAIL bad_mem_adr: got stat=%0d en=%0h expected 3/0", bus.stat, bus.stage_en);
        else pass_cnt++;
    endtask

    task automatic test_mem_timeout();
        restart();
        exec_instr(4'd4, 64'd8, 64'd10, 64'd0, 1'b0, -1);
        chk_cnt++;
        if (obs_mem !== 15 || bus.stage_en !== 6'd0)
            $display("[TB] FAIL timeout_cycles: got mem=%0d en=%0h expected 15/0", obs_mem, bus.stage_en);
        else pass_cnt++;
        chk_cnt++;
        if (bus.stat !== 3'd3 || bus.retired !== 32'd0 || bus.p_ctr !== 64'd0)
            $display("[TB] FAIL timeout_stat: got stat=%0d ret=%0d pc=%0h expected 3/0/0",
                     bus.stat, bus.retired, bus.p_ctr);
        else pass_cnt++;
    endtask

    task automatic test_dmem_error();
        restart();
        bus.in_code = 4'd5;
        tick();
        tick();
        tick();
        chk_cnt++;
        if (bus.stage_en !== 6'b001000) $display("[TB] FAIL dmem_reach_mem: got %0h expected 8", bus.stage_en);
        else pass_cnt++;
        bus.dmem_error = 1'b1;
        bus.mem_done   = 1'b1;
        tick();
        bus.dmem_error = 1'b0;
        bus.mem_done   = 1'b0;
        chk_cnt++;
        if (bus.stat !== 3'd3 || bus.stage_en !== 6'd0 || bus.retired !== 32'd0)
            $display("[TB] FAIL dmem_over_done: got stat=%0d en=%0h ret=%0d expected 3/0/0",
                     bus.stat, bus.stage_en, bus.retired);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_mem();
        restart();
        exec_instr(4'd1, 64'd0, 64'd200, 64'd0, 1'b0, 0);
        clear_inputs();
        bus.in_code = 4'd5;
        for (int k = 0; k < 5; k++) tick();
        chk_cnt++;
        if (bus.stage_en !== 6'b001000 || bus.p_ctr !== 64'd200)
            $display("[TB] FAIL midmem_waiting: got en=%0h pc=%0h expected 8/c8", bus.stage_en, bus.p_ctr);
        else pass_cnt++;
        reset_n = 1'b0;
        tick();
        chk_cnt++;
        if (bus.stage_en !== 6'd0 || bus.p_ctr !== 64'd0 || bus.running !== 1'b0 ||
            bus.retired !== 32'd0 || bus.stat !== 3'd1)
            $display("[TB] FAIL midmem_reset: got en=%0h pc=%0h run=%b ret=%0d stat=%0d expected 0/0/0/0/1",
                     bus.stage_en, bus.p_ctr, bus.running, bus.retired, bus.stat);
        else pass_cnt++;
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        chk_cnt  = 0;
        pass_cnt = 0;
        reset_n  = 1'b0;
        clear_inputs();
        test_reset();
        test_irmovq();
        test_jxx();
        test_ret_wait();
        test_random();
        test_fetch_limit();
        test_halt();
        test_fetch_errors();
        test_mem_timeout();
        test_dmem_error();
        test_reset_mid_mem();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/seq_stage_ctrl.md
Name: seq_stage_ctrl

Overview:
Sequencing controller for the single-cycle-per-stage Y86-64 SEQ datapath. It owns the program counter and steps fetch, decode, execute, memory, writeback and PC-update with one-hot stage strobes. It selects the next PC and tracks processor status (AOK/HLT/ADR/INS) from fetch and memory exceptions. It sits above fetch_seq and the decode/execute/memory stage blocks and drives their p_ctr and stage enables.

Parameters:
RESET_PC, 64'd0, PC value loaded on reset and on start
MEM_LIMIT, 64'd1023, highest legal instruction/data byte address
MEM_TIMEOUT, 4'd15, max cycles to wait for mem_done before raising ADR

Ports:
clock  input  1  system clock, all state updates on posedge
reset_n  input  1  synchronous active-low reset
start  input  1  level; leaves IDLE when high
in_code  input  4  icode from fetch
cnd  input  1  condition result from execute (jXX/cmovXX)
val_c  input  64  constant/destination from fetch
val_p  input  64  fall-through PC from fetch
val_m  input  64  value read by memory stage (ret target)
flag_halt  input  1  fetch saw halt
bad_mem  input  1  fetch address fault
in_error  input  1  fetch invalid icode
mem_done  input  1  memory stage access complete
dmem_error  input  1  memory stage address fault
p_ctr  output  64  current PC to fetch
stage_en  output  6  one-hot strobe {pcupd,wb,mem,exe,dec,fetch}, bit0 = fetch
stat  output  3  1=AOK 2=HLT 3=ADR 4=INS
running  output  1  high in any stage state
retired  output  32  instructions completed

Behaviour:
- Reset (reset_n low at posedge, wins over all else): state IDLE, p_ctr=RESET_PC, stage_en=0, stat=AOK, running=0, retired=0, timeout counter=0.
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALTED, FAULT. stage_en is a registered one-hot that is high during the matching state only.
- IDLE: start=1 -> FETCH next cycle, p_ctr=RESET_PC, stat=AOK.
- FETCH (1 cycle): outputs of fetch_seq are sampled at the end of the cycle. in_error -> FAULT, stat=INS. bad_mem, or p_ctr>MEM_LIMIT, -> FAULT, stat=ADR. INS takes priority over ADR. flag_halt -> HALTED, stat=HLT, p_ctr=val_p, retired+1. Otherwise -> DECODE.
- DECODE, EXECUTE: 1 cycle each. cnd is latched at the end of EXECUTE.
- MEMORY: for in_code 4,5,8,9,10,11, wait for mem_done. Other icodes advance after 1 cycle.
  - dmem_error in any MEMORY cycle -> FAULT, stat=ADR; this takes priority over a simultaneous mem_done.
  - The timeout counter increments each waiting cycle. If it reaches MEM_TIMEOUT without mem_done -> FAULT, stat=ADR. The counter clears on leaving MEMORY.
  - val_m is latched on mem_done.
- WRITEBACK: 1 cycle -> PCUPD.
- PCUPD: 1 cycle. Next PC:
  - icode 8 (call) -> val_c
  - icode 7 (jXX) with latched cnd=1 -> val_c
  - icode 9 (ret) -> latched val_m
  - otherwise val_p
  - retired increments and wraps at 2^32. Next state FETCH.
- HALTED, FAULT: stay there, running=0, stat held. Only reset_n exits; start is ignored.
- Reset asserted in any state, including mid-MEMORY wait, aborts immediately with no retire increment.
- p_ctr changes only in PCUPD, on halt, or on reset/start.

Decomposition:
- Package y86_pkg holds:
  - icode constants (HALT=0 ... POPQ=11)
  - stat codes AOK/HLT/ADR/INS
  - state enum
  - stage_en bit indices
- One natural sub-module: seq_next_pc, a combinational next-PC mux taking icode, cnd, val_c, val_p, val_m. Everything else stays in seq_stage_ctrl.

Test Plan:
- Reset then start, with fetch returning irmovq (icode 3, val_p=10) -> stage_en walks 1,2,4,8,16,32 over 6 cycles; p_ctr=10; retired=1.
- jXX icode 7, val_c=39, val_p=39, cnd=0, then repeat with cnd=1 and val_c=122 -> p_ctr=39 then 122.
- ret icode 9 with mem_done after 3 wait cycles and val_m=0x46 -> MEMORY lasts 4 cycles; p_ctr=0x46.
- Fetch of halt, flag_halt=1 at p_ctr=70 -> HALTED; stat=2; p_ctr=71; running=0; start pulses ignored.
- in_error=1 together with bad_mem=1 -> stat=4 (INS); mem instruction with mem_done never asserted -> stat=3 after MEM_TIMEOUT=15 wait cycles.
- reset_n low during a MEMORY wait -> next cycle IDLE, p_ctr=0, retired unchanged at 0, stage_en=0.
